// File: rtl/pif_xi_bridge.sv
// Byte-level I2C slave events to pifctl XI register bus, with XO readback
// prefetched into a one-byte transmit holding register.
module pif_xi_bridge #(
    parameter int ADDR_W = 4,
    parameter int SUBA_W = 4,
    parameter int DATA_W = 6,
    parameter int RD_LAT = 5
) (
    input  logic              xclk,
    input  logic              sys_rst,
    input  logic              i2c_start,
    input  logic              i2c_rnw,
    input  logic              i2c_stop,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rd_req,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              rd_underrun,
    output logic              XI_PWr,
    output logic [ADDR_W-1:0] XI_PRWA,
    output logic              XI_PRdFinished,
    output logic [SUBA_W-1:0] XI_PRdSubA,
    output logic [DATA_W-1:0] XI_PD,
    input  logic [7:0]        XO
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        WR_DATA,
        RD_FETCH,
        RD_READY
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] fetch_cnt;

    // Upper received bits are deliberately dropped when DATA_W/ADDR_W < 8.
    logic unused_rx_bits;
    assign unused_rx_bits = ^rx_data;

    // NOTE: every register, including the tx holding byte, is cleared on reset so
    // that a reset mid-transfer cannot leave a stale strobe or readback visible.
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            state          <= IDLE;
            fetch_cnt      <= '0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            rd_underrun    <= 1'b0;
            XI_PWr         <= 1'b0;
            XI_PRWA        <= '0;
            XI_PRdFinished <= 1'b0;
            XI_PRdSubA     <= '0;
            XI_PD          <= '0;
        end else begin
            // NOTE: non-blocking defaults make the strobes single-cycle; a later
            // assignment in the same block overrides them for this edge only.
            XI_PWr         <= 1'b0;
            XI_PRdFinished <= 1'b0;
            rd_underrun    <= rd_req && !tx_valid;

            if (i2c_start) begin
                tx_valid <= 1'b0;
                if (i2c_rnw) begin
                    XI_PRdSubA <= '0;
                    fetch_cnt  <= CNT_W'(RD_LAT);
                    state      <= RD_FETCH;
                end else begin
                    state <= GET_ADDR;
                end
            end else begin
                case (state)
                    GET_ADDR: begin
                        if (rx_valid) begin
                            XI_PRWA    <= rx_data[ADDR_W-1:0];
                            XI_PRdSubA <= '0;
                            state      <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (rx_valid) begin
                            XI_PD  <= rx_data[DATA_W-1:0];
                            XI_PWr <= 1'b1;
                        end
                    end
                    RD_FETCH: begin
                        // XO reflects the current sub-address once the count reaches 1.
                        if (fetch_cnt == CNT_W'(1)) begin
                            tx_data   <= XO;
                            tx_valid  <= 1'b1;
                            fetch_cnt <= '0;
                            state     <= RD_READY;
                        end else begin
                            fetch_cnt <= fetch_cnt - 1'b1;
                        end
                    end
                    RD_READY: begin
                        if (rd_req) begin
                            tx_valid       <= 1'b0;
                            XI_PRdFinished <= 1'b1;
                            XI_PRdSubA     <= XI_PRdSubA + 1'b1;
                            fetch_cnt      <= CNT_W'(RD_LAT);
                            state          <= RD_FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase

                // STOP ranks below the byte event: the byte above is still processed.
                if (i2c_stop) begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pif_xi_bridge.sv
// Directed bench for pif_xi_bridge: vector table for write/idle behaviour and
// hand sequences for read latency, wrap, underrun and reset against a pifctl model.
module tb_pif_xi_bridge;

    localparam int ADDR_W = 4;
    localparam int SUBA_W = 4;
    localparam int DATA_W = 6;
    localparam int RD_LAT = 5;

    logic              xclk = 1'b0;
    logic              sys_rst = 1'b0;
    logic              i2c_start = 1'b0;
    logic              i2c_rnw = 1'b0;
    logic              i2c_stop = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = '0;
    logic              rd_req = 1'b0;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              rd_underrun;
    logic              XI_PWr;
    logic [ADDR_W-1:0] XI_PRWA;
    logic              XI_PRdFinished;
    logic [SUBA_W-1:0] XI_PRdSubA;
    logic [DATA_W-1:0] XI_PD;
    logic [7:0]        XO;

    int checks = 0;
    int errors = 0;
    int fin_cnt = 0;
    int excl_viol = 0;

    pif_xi_bridge #(
        .ADDR_W(ADDR_W), .SUBA_W(SUBA_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)
    ) dut (
        .xclk(xclk), .sys_rst(sys_rst), .i2c_start(i2c_start), .i2c_rnw(i2c_rnw),
        .i2c_stop(i2c_stop), .rx_valid(rx_valid), .rx_data(rx_data), .rd_req(rd_req),
        .tx_data(tx_data), .tx_valid(tx_valid), .rd_underrun(rd_underrun),
        .XI_PWr(XI_PWr), .XI_PRWA(XI_PRWA), .XI_PRdFinished(XI_PRdFinished),
        .XI_PRdSubA(XI_PRdSubA), .XI_PD(XI_PD), .XO(XO)
    );

    always #5 xclk = ~xclk;

    // pifctl readback: register 0 holds ID 0xA5 at sub 0 and scratch 0x55 at sub 1.
    function automatic logic [7:0] pif_rd(input logic [3:0] a, input logic [3:0] s);
        if (a == 4'd0 && s == 4'd0) return 8'hA5;
        if (a == 4'd0 && s == 4'd1) return 8'h55;
        return {a, s};
    endfunction

    // XO is valid in the RD_LAT-th cycle counting the address-change cycle as 1.
    logic [7:0] pipe [RD_LAT-1];
    always @(posedge xclk) begin
        pipe[0] <= pif_rd(XI_PRWA, XI_PRdSubA);
        for (int i = 1; i < RD_LAT - 1; i++) pipe[i] <= pipe[i-1];
    end
    assign XO = pipe[RD_LAT-2];

    always @(posedge xclk) begin
        if (XI_PRdFinished) fin_cnt++;
        if (XI_PWr && XI_PRdFinished) excl_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic start, input logic rnw, input logic stop,
                        input logic rxv, input logic [7:0] rxd, input logic rdq);
        sys_rst = rst; i2c_start = start; i2c_rnw = rnw; i2c_stop = stop;
        rx_valid = rxv; rx_data = rxd; rd_req = rdq;
        @(posedge xclk);
        #1;
        sys_rst = 0; i2c_start = 0; i2c_rnw = 0; i2c_stop = 0;
        rx_valid = 0; rx_data = '0; rd_req = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 8'h00, 0);
    endtask

    task automatic wait_txv(output int n);
        n = 0;
        while (!tx_valid && n < 20) begin
            idle();
            n++;
        end
        if (!tx_valid) check("txv_timeout", 32'(tx_valid), 32'd1);
    endtask

    typedef struct {
        string      name;
        logic       rst, start, rnw, stop, rxv;
        logic [7:0] rxd;
        logic       rdq;
        logic       e_pwr;
        logic [3:0] e_prwa;
        logic [5:0] e_pd;
        logic       e_fin;
        logic [3:0] e_suba;
        logic       e_txv;
        logic       e_und;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic rst, start, rnw, stop, rxv,
                                input logic [7:0] rxd, input logic rdq, input logic pwr,
                                input logic [3:0] prwa, input logic [5:0] pd, input logic fin,
                                input logic [3:0] suba, input logic txv, input logic und);
        vec_t v;
        v.name = nm; v.rst = rst; v.start = start; v.rnw = rnw; v.stop = stop;
        v.rxv = rxv; v.rxd = rxd; v.rdq = rdq; v.e_pwr = pwr; v.e_prwa = prwa;
        v.e_pd = pd; v.e_fin = fin; v.e_suba = suba; v.e_txv = txv; v.e_und = und;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        int n;
        int fin0;
        logic [3:0] s;

        //                name          rst st rnw sp rxv rxd    rdq  pwr prwa pd     fin sub txv und
        vecs[0]  = mk("reset",          1, 0, 0, 0, 0, 8'h00, 0,   0, 4'h0, 6'h00, 0, 0, 0, 0);
        vecs[1]  = mk("wr_start",       0, 1, 0, 0, 0, 8'h00, 0,   0, 4'h0, 6'h00, 0, 0, 0, 0);
        vecs[2]  = mk("wr_addr",        0, 0, 0, 0, 1, 8'h03, 0,   0, 4'h3, 6'h00, 0, 0, 0, 0);
        vecs[3]  = mk("wr_data",        0, 0, 0, 0, 1, 8'h2A, 0,   1, 4'h3, 6'h2A, 0, 0, 0, 0);
        vecs[4]  = mk("wr_gap",         0, 0, 0, 0, 0, 8'h00, 0,   0, 4'h3, 6'h2A, 0, 0, 0, 0);
        vecs[5]  = mk("wr_stop",        0, 0, 0, 1, 0, 8'h00, 0,   0, 4'h3, 6'h2A, 0, 0, 0, 0);
        vecs[6]  = mk("idle_rx",        0, 0, 0, 0, 1, 8'h15, 0,   0, 4'h3, 6'h2A, 0, 0, 0, 0);
        vecs[7]  = mk("idle_rdq",       0, 0, 0, 0, 0, 8'h00, 1,   0, 4'h3, 6'h2A, 0, 0, 0, 1);
        vecs[8]  = mk("idle_quiet",     0, 0, 0, 0, 0, 8'h00, 0,   0, 4'h3, 6'h2A, 0, 0, 0, 0);
        vecs[9]  = mk("col_start",      0, 1, 0, 0, 0, 8'h00, 0,   0, 4'h3, 6'h2A, 0, 0, 0, 0);
        vecs[10] = mk("col_addr_trunc", 0, 0, 0, 0, 1, 8'hF7, 0,   0, 4'h7, 6'h2A, 0, 0, 0, 0);
        vecs[11] = mk("col_data_trunc", 0, 0, 0, 0, 1, 8'h81, 0,   1, 4'h7, 6'h01, 0, 0, 0, 0);
        vecs[12] = mk("col_gap",        0, 0, 0, 0, 0, 8'h00, 0,   0, 4'h7, 6'h01, 0, 0, 0, 0);
        vecs[13] = mk("col_rx_stop",    0, 0, 0, 1, 1, 8'h3F, 0,   1, 4'h7, 6'h3F, 0, 0, 0, 0);
        vecs[14] = mk("col_after_rx",   0, 0, 0, 0, 1, 8'h11, 0,   0, 4'h7, 6'h3F, 0, 0, 0, 0);
        vecs[15] = mk("col_after_gap",  0, 0, 0, 0, 0, 8'h00, 0,   0, 4'h7, 6'h3F, 0, 0, 0, 0);
        vecs[16] = mk("rs_start",       0, 1, 0, 0, 0, 8'h00, 0,   0, 4'h7, 6'h3F, 0, 0, 0, 0);
        vecs[17] = mk("rs_addr",        0, 0, 0, 0, 1, 8'h00, 0,   0, 4'h0, 6'h3F, 0, 0, 0, 0);

        repeat (2) @(posedge xclk);
        #1;
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].start, vecs[i].rnw, vecs[i].stop,
                 vecs[i].rxv, vecs[i].rxd, vecs[i].rdq);
            check({vecs[i].name, ".pwr"},  32'(XI_PWr),         32'(vecs[i].e_pwr));
            check({vecs[i].name, ".prwa"}, 32'(XI_PRWA),        32'(vecs[i].e_prwa));
            check({vecs[i].name, ".pd"},   32'(XI_PD),          32'(vecs[i].e_pd));
            check({vecs[i].name, ".fin"},  32'(XI_PRdFinished), 32'(vecs[i].e_fin));
            check({vecs[i].name, ".suba"}, 32'(XI_PRdSubA),     32'(vecs[i].e_suba));
            check({vecs[i].name, ".txv"},  32'(tx_valid),       32'(vecs[i].e_txv));
            check({vecs[i].name, ".und"},  32'(rd_underrun),    32'(vecs[i].e_und));
        end

        // Read after repeated START: first byte lands RD_LAT+1 cycles after start.
        step(0, 1, 1, 0, 0, 8'h00, 0);
        check("rd_start.txv", 32'(tx_valid), 32'd0);
        check("rd_start.pwr", 32'(XI_PWr), 32'd0);
        wait_txv(n);
        check("rd_first.latency", 32'(n), 32'(RD_LAT));
        check("rd_first.data", 32'(tx_data), 32'h A5);
        fin0 = fin_cnt;
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("rd_ack.fin", 32'(XI_PRdFinished), 32'd1);
        check("rd_ack.suba", 32'(XI_PRdSubA), 32'd1);
        check("rd_ack.txv", 32'(tx_valid), 32'd0);
        check("rd_ack.und", 32'(rd_underrun), 32'd0);
        idle();
        check("rd_ack_gap.fin", 32'(XI_PRdFinished), 32'd0);
        wait_txv(n);
        check("rd_second.latency", 32'(n), 32'(RD_LAT - 1));
        check("rd_second.data", 32'(tx_data), 32'h55);

        // Underrun during fetch: pulse only, fetch timing and sub-address unaffected.
        step(0, 0, 0, 0, 0, 8'h00, 1);
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("under.und", 32'(rd_underrun), 32'd1);
        check("under.suba", 32'(XI_PRdSubA), 32'd2);
        check("under.fin", 32'(XI_PRdFinished), 32'd0);
        idle();
        check("under_gap.und", 32'(rd_underrun), 32'd0);
        wait_txv(n);
        check("under.latency", 32'(n), 32'(RD_LAT - 2));
        check("under.data", 32'(tx_data), 32'h02);
        check("under.fin_total", 32'(fin_cnt - fin0), 32'd2);

        // STOP while a byte is held: tx dropped, addresses kept.
        step(0, 0, 0, 1, 0, 8'h00, 0);
        check("rd_stop.txv", 32'(tx_valid), 32'd0);
        check("rd_stop.suba", 32'(XI_PRdSubA), 32'd2);
        check("rd_stop.prwa", 32'(XI_PRWA), 32'd0);
        step(0, 0, 0, 0, 0, 8'h00, 1);
        check("idle_rdq.und", 32'(rd_underrun), 32'd1);
        check("idle_rdq.suba", 32'(XI_PRdSubA), 32'd2);

        // Sub-address wraps after 2**SUBA_W reads.
        step(0, 1, 1, 0, 0, 8'h00, 0);
        check("wrap_start.suba", 32'(XI_PRdSubA), 32'd0);
        wait_txv(n);
        check("wrap_first.data", 32'(tx_data), 32'hA5);
        fin0 = fin_cnt;
        for (int i = 0; i < 16; i++) begin
            s = 4'(i + 1);
            step(0, 0, 0, 0, 0, 8'h00, 1);
            check($sformatf("wrap%0d.suba", i), 32'(XI_PRdSubA), 32'(s));
            wait_txv(n);
            check($sformatf("wrap%0d.latency", i), 32'(n), 32'(RD_LAT));
            check($sformatf("wrap%0d.data", i), 32'(tx_data), 32'(pif_rd(4'h0, s)));
        end
        check("wrap.fin_total", 32'(fin_cnt - fin0), 32'd16);
        check("wrap.suba_final", 32'(XI_PRdSubA), 32'd0);

        // Reset in the middle of a fetch clears everything and stops the fetch.
        step(0, 0, 0, 0, 0, 8'h00, 1);
        idle();
        step(1, 0, 0, 0, 0, 8'h00, 0);
        check("rst_mid.pwr", 32'(XI_PWr), 32'd0);
        check("rst_mid.prwa", 32'(XI_PRWA), 32'd0);
        check("rst_mid.pd", 32'(XI_PD), 32'd0);
        check("rst_mid.fin", 32'(XI_PRdFinished), 32'd0);
        check("rst_mid.suba", 32'(XI_PRdSubA), 32'd0);
        check("rst_mid.txv", 32'(tx_valid), 32'd0);
        check("rst_mid.tx_data", 32'(tx_data), 32'd0);
        check("rst_mid.und", 32'(rd_underrun), 32'd0);
        repeat (RD_LAT + 2) idle();
        check("rst_after.txv", 32'(tx_valid), 32'd0);
        step(0, 0, 0, 0, 1, 8'h2B, 0);
        check("rst_after_rx.pwr", 32'(XI_PWr), 32'd0);
        check("rst_after_rx.pd", 32'(XI_PD), 32'd0);

        check("pwr_fin_exclusive", 32'(excl_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
